pwm_duty_decoder: RTL

- Receive side of the team's LED PWM scheme. Recovers the 8-bit duty value from a free-running PWM line whose period is 2^CNT_W clk cycles and whose high time equals the duty code.
- Used for loopback self-test of LED drive and for reading PWM outputs from other boards.
- Reports one measured duty per PWM period, plus period-error and stuck-line flags.

---
 rtl/pwm_duty_decoder.sv | 101 ++++++++++
 1 files changed

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: recovers duty, period error and stuck status from a PWM line (optional PWM_DUTY_AVG_EN: 4-tap duty average)
module pwm_duty_decoder #(
  parameter int CNT_W = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty,
  output logic             duty_valid,
  output logic             period_err,
  output logic             stuck
);
  localparam int PER_W = CNT_W + 2;
  localparam int HI_W = CNT_W + 1;
  localparam logic [PER_W-1:0] PER = PER_W'(1) << CNT_W;
  localparam logic [PER_W-1:0] TMO = PER_W'(TIMEOUT);
  localparam logic [HI_W-1:0] HI_MAX = HI_W'({CNT_W{1'b1}});
  typedef enum logic [1:0] {S_SYNC, S_MEAS, S_STUCK} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic s, s_d, rise, meas_ev, tmo;
  logic [PER_W-1:0] per_cnt;
  logic [HI_W-1:0] hi_cnt;
  logic [CNT_W-1:0] meas, meas_out;
  assign s = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign meas_ev = rise && state == S_MEAS;
  assign tmo = !rise && per_cnt == TMO;
  assign meas = hi_cnt > HI_MAX ? '1 : hi_cnt[CNT_W-1:0];
  // metastability synchroniser plus one delay flop for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      s_d <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_d <= s;
    end
`ifdef PWM_DUTY_AVG_EN
  logic [CNT_W-1:0] taps [4];
  logic [PER_W-1:0] sum, sum_nxt;
  logic seeded;
  assign sum_nxt = seeded ? sum - {2'b00, taps[3]} + {2'b00, meas} : {meas, 2'b00};
  assign meas_out = CNT_W'(sum_nxt >> 2);
  // moving-average taps; the first measurement after reset or stuck seeds all four
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      taps <= '{default: '0};
      sum <= '0;
      seeded <= 1'b0;
    end else if (meas_ev) begin
      taps[0] <= meas;
      taps[1] <= seeded ? taps[0] : meas;
      taps[2] <= seeded ? taps[1] : meas;
      taps[3] <= seeded ? taps[2] : meas;
      sum <= sum_nxt;
      seeded <= 1'b1;
    end else if (tmo) begin
      taps <= '{default: '0};
      sum <= '0;
      seeded <= 1'b0;
    end
`else
  assign meas_out = meas;
`endif
  // measurement FSM: counters, per-period report and stuck-line timeout
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_SYNC;
      per_cnt <= '0;
      hi_cnt <= '0;
      duty <= '0;
      duty_valid <= 1'b0;
      period_err <= 1'b0;
      stuck <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      per_cnt <= per_cnt == TMO ? TMO : per_cnt + PER_W'(1);
      hi_cnt <= s && hi_cnt != HI_MAX ? hi_cnt + HI_W'(1) : hi_cnt;
      if (rise) begin
        per_cnt <= PER_W'(1);
        hi_cnt <= HI_W'(1);
        stuck <= 1'b0;
        state <= S_MEAS;
        if (state == S_MEAS) begin
          duty <= meas_out;
          period_err <= per_cnt != PER;
          duty_valid <= 1'b1;
        end
      end else if (tmo) begin
        per_cnt <= PER_W'(1);
        stuck <= 1'b1;
        duty <= s ? '1 : '0;
        period_err <= 1'b0;
        duty_valid <= 1'b1;
        state <= S_STUCK;
      end
    end
endmodule
